fetch_sequencer: RTL and testbench

- Program-counter and instruction-sequencing stage of the CPU.
- Fetches each instruction from instruction memory over a req/ack handshake and holds it in an instruction register.
- Drives the jump-flag field to the `condition` block and consumes its `out` result, together with the A-register value, to choose the next PC.
- Detects the halt idiom (unconditional jump to self) and stops.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/pc_next.sv | 28 ++
 rtl/fetch_sequencer.sv | 106 ++++++++++
 tb/tb_fetch_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: jump-flag field layout, sequencer states and the
// instruction-format constants used to decode jumps and the halt idiom.
package cpu_pkg;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } jmp_flag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  localparam int CI_BIT = 15;
  localparam int JMP_LSB = 0;
  localparam logic [2:0] JMP_ALWAYS = 3'b111;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection and halt-idiom detection
// (an unconditional jump whose target is the current pc).
module pc_next
  import cpu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PC_WIDTH = 16
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                is_jump,
  input  jmp_flag_t           jmp,
  input  logic                cond_true,
  input  logic [WIDTH-1:0]    a_value,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                halt_hit
);

  logic                taken;
  logic [PC_WIDTH-1:0] target;

  always_comb begin
    taken    = is_jump & cond_true;
    target   = a_value[PC_WIDTH-1:0];
    next_pc  = taken ? target : pc + PC_WIDTH'(1);
    halt_hit = taken && (jmp == JMP_ALWAYS) && (target == pc);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and instruction sequencer: fetches over req/ack,
// executes from the instruction register, picks the next pc, stops on halt.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                     WIDTH    = 16,
  parameter int                     PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WIDTH-1:0]    imem_rdata,
  output logic [WIDTH-1:0]    instr,
  output logic                instr_valid,
  input  logic                exec_stall,
  output jmp_flag_t           jmp,
  input  logic                cond_true,
  input  logic [WIDTH-1:0]    a_value,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic [31:0]         retired,
  output seq_state_t          state
);

  // Handshake: imem_req rises on entering FETCH and stays high with
  // imem_addr == pc until a cycle with imem_ack=1, in which imem_rdata is
  // captured; memory never acks without a pending req.

  seq_state_t          next_state;
  logic                is_jump;
  logic                retire;
  logic [PC_WIDTH-1:0] next_pc;
  logic                halt_hit;

  pc_next #(
    .WIDTH   (WIDTH),
    .PC_WIDTH(PC_WIDTH)
  ) u_pc_next (
    .pc       (pc),
    .is_jump  (is_jump),
    .jmp      (jmp),
    .cond_true(cond_true),
    .a_value  (a_value),
    .next_pc  (next_pc),
    .halt_hit (halt_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (run) next_state = FETCH;
      FETCH: if (imem_ack) next_state = EXEC;
      EXEC: begin
        if (!exec_stall) begin
          if (halt_hit) next_state = HALT;
          else if (run) next_state = FETCH;
          else next_state = IDLE;
        end
      end
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == FETCH);
    imem_addr   = pc;
    instr_valid = (state == EXEC);
    halted      = (state == HALT);
    retire      = (state == EXEC) && !exec_stall;
    is_jump     = instr[CI_BIT];
    jmp         = is_jump ? jmp_flag_t'(instr[JMP_LSB+2:JMP_LSB]) : jmp_flag_t'(3'b000);
  end

  // cond_true and a_value only matter in the retiring EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      instr   <= '0;
      retired <= '0;
    end else begin
      if (state == FETCH && imem_ack) begin
        instr <= imem_rdata;
      end
      if (retire) begin
        retired <= retired + 32'd1;
        if (!halt_hit) begin
          pc <= next_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer with a reference pc model and a
// queue-based scoreboard checked by an independent monitor.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        exec_stall = 1'b0;
  jmp_flag_t   jmp;
  logic        cond_true = 1'b0;
  logic [15:0] a_value = '0;
  logic [15:0] pc;
  logic        halted;
  logic [31:0] retired;
  seq_state_t  state;

  fetch_sequencer #(.WIDTH(16), .PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .exec_stall(exec_stall), .jmp(jmp), .cond_true(cond_true),
    .a_value(a_value), .pc(pc), .halted(halted), .retired(retired),
    .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [15:0] addr_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] model_pc = 16'h0000;
  int          model_ret = 0;
  bit          model_halt = 1'b0;
  int          mon_ret = 0;
  logic [15:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req) begin
        if (addr_q.size() == 0) fail_now("unexpected_fetch");
        else begin
          check("fetch_addr", 32'(imem_addr), 32'(addr_q[0]));
          if (imem_ack) void'(addr_q.pop_front());
        end
      end
      if (instr_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_exec");
        else begin
          mon_e = exp_q[0];
          check("instr", 32'(instr), 32'(mon_e));
          check("jmp", 32'(jmp), mon_e[15] ? 32'(mon_e[2:0]) : 32'd0);
          if (!exec_stall) begin
            check("retired", retired, 32'(mon_ret));
            mon_ret++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_instr(input logic [15:0] ins, input int dly, input int stall,
                          input logic cond, input logic [15:0] aval, input bit drop_run);
    bit taken;
    wait_req();
    if (!imem_req) begin
      fail_now("req_timeout");
      return;
    end
    if (drop_run) run = 1'b0;
    repeat (dly) begin
      imem_rdata = 16'($urandom);
      @(posedge clk); #1;
    end
    imem_ack = 1'b1;
    imem_rdata = ins;
    exp_q.push_back(ins);
    @(posedge clk); #1;
    imem_ack = 1'b0;
    imem_rdata = 16'($urandom);
    check("ack_to_valid", 32'(instr_valid), 32'd1);
    repeat (stall) begin
      exec_stall = 1'b1;
      cond_true = 1'($urandom);
      a_value = 16'($urandom);
      @(posedge clk); #1;
    end
    exec_stall = 1'b0;
    cond_true = cond;
    a_value = aval;
    taken = ins[15] & cond;
    if (taken && ins[2:0] == 3'b111 && aval == model_pc) model_halt = 1'b1;
    else begin
      model_pc = taken ? aval : model_pc + 16'd1;
      addr_q.push_back(model_pc);
    end
    model_ret++;
    @(posedge clk); #1;
    cond_true = 1'($urandom);
    a_value = 16'($urandom);
    if (drop_run) begin
      check("idle_after_drop", 32'(imem_req), 32'd0);
      repeat (2) begin @(posedge clk); #1; end
      run = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ins, aval;
    logic        c;
    addr_q.push_back(16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst_n = 1'b1;
    run = 1'b1;

    // Reset in the middle of a fetch.
    wait_req();
    check("pre_reset_req", 32'(imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midfetch_req", 32'(imem_req), 32'd0);
    check("midfetch_pc", 32'(pc), 32'd0);
    check("midfetch_state", 32'(state), 32'(IDLE));
    addr_q.delete();
    addr_q.push_back(16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Zero-wait constants, then jump-on-nothing.
    do_instr(16'h0005, 0, 0, 1'b1, 16'h1234, 1'b0);
    do_instr(16'h8000, 0, 0, 1'b0, 16'h0777, 1'b0);
    check("pc_after_two", 32'(pc), 32'h2);
    check("retired_two", retired, 32'd2);

    // Taken and not-taken conditional jump.
    do_instr(16'h8302, 0, 0, 1'b1, 16'h0040, 1'b0);
    do_instr(16'h8302, 0, 0, 1'b0, 16'h0099, 1'b0);

    // Slow memory plus execute stall.
    do_instr(16'h0123, 3, 2, 1'b1, 16'h0000, 1'b0);
    check("retired_stall", retired, 32'(model_ret));

    for (int i = 0; i < 50; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 1) == 0) ins[15] = 1'b0;
      aval = ($urandom_range(0, 3) == 0) ? model_pc : 16'($urandom);
      c = 1'($urandom);
      if (ins[15] && c && ins[2:0] == 3'b111 && aval == model_pc) aval = aval ^ 16'h0001;
      do_instr(ins, $urandom_range(0, 3), $urandom_range(0, 2), c, aval,
               $urandom_range(0, 7) == 0);
    end

    // pc wrap from 0xFFFF.
    do_instr(16'h8001, 0, 0, 1'b1, 16'hFFFF, 1'b0);
    do_instr(16'h1234, 0, 0, 1'b1, 16'h5555, 1'b0);
    check("pc_wrap", 32'(pc), 32'h0);

    // Halt idiom at 0x0010.
    do_instr(16'h8001, 0, 0, 1'b1, 16'h0010, 1'b0);
    do_instr(16'h8007, 0, 0, 1'b1, 16'h0010, 1'b0);
    check("model_halt", 32'(model_halt), 32'(halted));
    repeat (5) begin
      check("halted", 32'(halted), 32'd1);
      check("halt_no_req", 32'(imem_req), 32'd0);
      @(posedge clk); #1;
    end
    check("halt_pc", 32'(pc), 32'h0010);
    check("final_retired", retired, 32'(model_ret));
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
